// File: rtl/bist_resp_shifter_pkg.sv
// Shared definitions for the BIST response shifter: state encoding, word geometry
// and the byte-lane split also used by the BIST instruction buffer.
package bist_resp_shifter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_SHIFT  = 2'd2
    } state_t;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    localparam int COM_HI  = 15;
    localparam int COM_LO  = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    // Bit presented at the output end of the register for the chosen shift order.
    function automatic logic out_bit(input logic [WORD_W-1:0] word, input logic lsb_first);
        return lsb_first ? word[0] : word[WORD_W-1];
    endfunction

endpackage

// File: rtl/bist_resp_shifter.sv
// Serializes a 16-bit {command, data} response word onto TDO, one bit per TAP shift
// strobe, with busy/done status and an overrun flag for loads that arrive mid-word.
module bist_resp_shifter
    import bist_resp_shifter_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         res,
    input  logic [7:0]   In_com,
    input  logic [7:0]   In_data,
    input  logic         Load_en,
    input  logic         Shift_en,
    output logic         Tdo,
    output logic         Busy,
    output logic         Done,
    output logic         Overrun,
    output state_t       dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);

    state_t              state;
    logic [WORD_W-1:0]   sreg;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_W-1:0]   load_word;
    logic [WORD_W-1:0]   shifted;

    always_comb begin
        load_word                  = '0;
        load_word[COM_HI:COM_LO]   = In_com;
        load_word[DATA_HI:DATA_LO] = In_data;
    end

    assign shifted = LSB_FIRST ? {1'b0, sreg[WORD_W-1:1]} : {sreg[WORD_W-2:0], 1'b0};

    // Load_en and Shift_en are single-cycle strobes with no back-pressure: a load is
    // taken only in IDLE (otherwise flagged by Overrun), a shift only while busy.
    // Tdo is registered with the bit that the next state will expose.
    always_ff @(posedge clk) begin
        if (res) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            cnt     <= '0;
            Tdo     <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            Done    <= 1'b0;
            Overrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Load_en) begin
                        sreg  <= load_word;
                        cnt   <= '0;
                        Tdo   <= out_bit(load_word, LSB_FIRST);
                        Busy  <= 1'b1;
                        state <= ST_LOADED;
                    end
                end
                ST_LOADED, ST_SHIFT: begin
                    if (Load_en) begin
                        Overrun <= 1'b1;
                    end
                    if (Shift_en) begin
                        sreg <= shifted;
                        cnt  <= cnt + 1'b1;
                        if (state == ST_SHIFT && cnt == CNT_LAST) begin
                            state <= ST_IDLE;
                            Tdo   <= 1'b0;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                            Tdo   <= out_bit(shifted, LSB_FIRST);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    Tdo   <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_bist_resp_shifter.sv
// Directed bench for bist_resp_shifter: one LSB-first and one MSB-first instance,
// each word checked bit by bit against hand-chosen vectors.
module tb_bist_resp_shifter;
    import bist_resp_shifter_pkg::*;

    logic clk = 1'b0;
    logic res = 1'b1;

    logic [7:0] com_l = '0, data_l = '0, com_m = '0, data_m = '0;
    logic load_l = 1'b0, shift_l = 1'b0, load_m = 1'b0, shift_m = 1'b0;
    logic tdo_l, busy_l, done_l, ovr_l;
    logic tdo_m, busy_m, done_m, ovr_m;
    state_t st_l, st_m;
    logic [CNT_W-1:0] cnt_l, cnt_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bist_resp_shifter #(.LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .res(res), .In_com(com_l), .In_data(data_l),
        .Load_en(load_l), .Shift_en(shift_l), .Tdo(tdo_l), .Busy(busy_l),
        .Done(done_l), .Overrun(ovr_l), .dbg_state(st_l), .dbg_cnt(cnt_l)
    );

    bist_resp_shifter #(.LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .res(res), .In_com(com_m), .In_data(data_m),
        .Load_en(load_m), .Shift_en(shift_m), .Tdo(tdo_m), .Busy(busy_m),
        .Done(done_m), .Overrun(ovr_m), .dbg_state(st_m), .dbg_cnt(cnt_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input bit msb, input logic [15:0] word);
        if (msb) begin
            com_m = word[15:8]; data_m = word[7:0]; load_m = 1'b1;
        end else begin
            com_l = word[15:8]; data_l = word[7:0]; load_l = 1'b1;
        end
        tick();
        load_m = 1'b0;
        load_l = 1'b0;
    endtask

    // Consumer samples Tdo in the same cycle it raises Shift_en.
    task automatic shift_word(input bit msb, input logic [15:0] word);
        for (int i = 0; i < 16; i++) begin
            check("tdo_bit", msb ? tdo_m : tdo_l, msb ? word[15-i] : word[i]);
            check("busy_in_word", msb ? busy_m : busy_l, 16'd1);
            check("no_early_done", msb ? done_m : done_l, 16'd0);
            if (msb) shift_m = 1'b1; else shift_l = 1'b1;
            tick();
        end
        shift_m = 1'b0;
        shift_l = 1'b0;
        check("busy_end", msb ? busy_m : busy_l, 16'd0);
        check("tdo_end", msb ? tdo_m : tdo_l, 16'd0);
        check("done_pulse", msb ? done_m : done_l, 16'd1);
        tick();
        check("done_clear", msb ? done_m : done_l, 16'd0);
    endtask

    initial begin
        // Reset held for two cycles
        res = 1'b1;
        tick();
        tick();
        check("rst_tdo", tdo_l, 16'd0);
        check("rst_busy", busy_l, 16'd0);
        check("rst_done", done_l, 16'd0);
        check("rst_ovr", ovr_l, 16'd0);
        check("rst_tdo_m", tdo_m, 16'd0);
        check("rst_busy_m", busy_m, 16'd0);
        res = 1'b0;

        // Shift strobes in IDLE are ignored
        shift_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_shift_tdo", tdo_l, 16'd0);
            check("idle_shift_done", done_l, 16'd0);
            check("idle_shift_busy", busy_l, 16'd0);
        end
        shift_l = 1'b0;

        // LSB-first word A53C
        load_word(1'b0, 16'hA53C);
        check("load_cnt", 16'(cnt_l), 16'd0);
        check("load_state", 16'(st_l), 16'(ST_LOADED));
        shift_word(1'b0, 16'hA53C);

        // MSB-first word 8001
        load_word(1'b1, 16'h8001);
        shift_word(1'b1, 16'h8001);

        // Overrun during shift 5 of word 0000, strobes gapped every other cycle
        load_word(1'b0, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            check("gap_tdo", tdo_l, 16'd0);
            shift_l = 1'b1;
            if (i == 4) begin
                com_l = 8'hFF; data_l = 8'hFF; load_l = 1'b1;
            end
            tick();
            shift_l = 1'b0;
            load_l = 1'b0;
            check("ovr_flag", ovr_l, (i == 4) ? 16'd1 : 16'd0);
            if (i < 15) begin
                check("gap_busy", busy_l, 16'd1);
                check("gap_no_done", done_l, 16'd0);
                tick();
                check("ovr_clear", ovr_l, 16'd0);
                check("gap_hold_cnt", 16'(cnt_l), 16'(i + 1));
            end
        end
        check("gap_done", done_l, 16'd1);
        check("gap_busy_end", busy_l, 16'd0);
        tick();
        check("gap_done_clear", done_l, 16'd0);

        // Load and shift together in IDLE: load wins
        com_l = 8'h00; data_l = 8'h01; load_l = 1'b1; shift_l = 1'b1;
        tick();
        load_l = 1'b0;
        shift_l = 1'b0;
        check("sim_tdo", tdo_l, 16'd1);
        check("sim_cnt", 16'(cnt_l), 16'd0);
        check("sim_state", 16'(st_l), 16'(ST_LOADED));
        tick();
        check("sim_hold_tdo", tdo_l, 16'd1);
        check("sim_hold_cnt", 16'(cnt_l), 16'd0);
        shift_word(1'b0, 16'h0001);

        // Reset after 7 shifts discards the word
        load_word(1'b0, 16'hC3F0);
        for (int i = 0; i < 7; i++) begin
            check("pre_rst_tdo", tdo_l, 16'(((16'hC3F0) >> i) & 16'd1));
            shift_l = 1'b1;
            tick();
        end
        shift_l = 1'b0;
        res = 1'b1;
        tick();
        res = 1'b0;
        check("mid_rst_busy", busy_l, 16'd0);
        check("mid_rst_tdo", tdo_l, 16'd0);
        check("mid_rst_done", done_l, 16'd0);
        check("mid_rst_state", 16'(st_l), 16'(ST_IDLE));
        tick();
        check("mid_rst_no_done", done_l, 16'd0);
        load_word(1'b0, 16'h5AA5);
        shift_word(1'b0, 16'h5AA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
